mul_hilo_sequencer: RTL and testbench

Multi-cycle signed multiply unit with HI/LO register pair for the 16-bit processor core. It serves mul/muli and mfhi/mflo.
- Accepts a multiply issue from the control unit and runs a radix-2 shift-add over DATA_W cycles.
- Commits the 2*DATA_W product to HI/LO.
- Raises a pipeline stall while busy and interlocks HI/LO reads against an in-flight multiply.
- Sits beside the ALU in EX; the ALU control's mul encoding is not used when this unit is present.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mul_shift_add_core.sv | 60 ++++++
 rtl/mul_hilo_sequencer.sv | 91 +++++++++
 tb/tb_mul_hilo_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: multiply-unit state encoding, the opcodes the control
// unit decodes into mul_start/mf_req, and the default datapath width.
package cpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MUL   = 4'b0001;
  localparam logic [3:0] OP_MFHI  = 4'b0010;
  localparam logic [3:0] OP_MFLO  = 4'b0011;
  localparam logic [3:0] OP_MULI  = 4'b0101;

endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add datapath on operand magnitudes; the sign is applied
// combinationally to the finished accumulator.
module mul_shift_add_core #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_W-1:0]     operand_a,
  input  logic [DATA_W-1:0]     operand_b,
  output logic [2*DATA_W-1:0]   product
);

  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplier;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic                neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] acc_full;

  // Negating 0x8000 yields 0x8000, which is the correct magnitude read as unsigned.
  assign a_mag = operand_a[DATA_W-1] ? -operand_a : operand_a;
  assign b_mag = operand_b[DATA_W-1] ? -operand_b : operand_b;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum = {1'b0, acc_hi};
    if (mplier[0]) sum = {1'b0, acc_hi} + {1'b0, mcand};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
    end else if (step) begin
      // The add carry lands in sum[DATA_W] and is shifted down into acc_hi.
      acc_hi <= sum[DATA_W:1];
      acc_lo <= {sum[0], acc_lo[DATA_W-1:1]};
      mplier <= mplier >> 1;
    end
  end

  assign acc_full = {acc_hi, acc_lo};
  assign product  = neg ? -acc_full : acc_full;

endmodule

// File: rtl/mul_hilo_sequencer.sv
// Multi-cycle signed multiply with HI/LO pair: sequences the shift-add core,
// commits the product and stalls the pipeline while a multiply is in flight.
module mul_hilo_sequencer #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mul_start,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  input  logic              mf_req,
  input  logic              mf_hi,
  output logic [DATA_W-1:0] mf_data,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic                load;
  logic                step;
  logic [2*DATA_W-1:0] product;

  // A flushed instruction must not issue, so flush also blocks a start in IDLE.
  assign load = (state == ST_IDLE) && mul_start && !flush;
  assign step = (state == ST_RUN) && !flush;

  mul_shift_add_core #(.DATA_W(DATA_W)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .product   (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!flush) begin
            hi <= product[2*DATA_W-1:DATA_W];
            lo <= product[DATA_W-1:0];
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE) && !flush;
  assign stall   = busy | (mf_req & busy);
  // Read-before-write: a read in the same IDLE cycle as an issue sees old HI/LO.
  assign mf_data = mf_hi ? hi : lo;

endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// Self-checking bench for mul_hilo_sequencer: directed scenarios plus random
// operands compared against a plain signed-multiply reference.
module tb_mul_hilo_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mul_start = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         flush = 1'b0;
  logic         mf_req = 1'b0;
  logic         mf_hi = 1'b0;
  logic [W-1:0] mf_data;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;

  mul_hilo_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mul_start (mul_start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .mf_req    (mf_req),
    .mf_hi     (mf_hi),
    .mf_data   (mf_data),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  // Issues one multiply and watches it to completion (stimulus only).
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int busy_n, output int done_n, output int done_at,
                         output bit timeout);
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    mul_start = 1'b1;
    @(posedge clk);
    #1 mul_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; timeout = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin done_n++; done_at = i; end
      if (!busy) begin timeout = 1'b0; break; end
      busy_n++;
    end
  endtask

  task automatic test_reset_state();
    @(negedge clk);
    checks++;
    if ({hi, lo, busy, done, stall} !== {32'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b", hi, lo, busy, done, stall);
    end
  endtask

  task automatic test_signed();
    int bn, dn, da; bit to;
    logic [2*W-1:0] exp_p;
    exp_p = ref_prod(16'hFFFE, 16'h0007);
    run_mul(16'hFFFE, 16'h0007, bn, dn, da, to);
    checks++;
    if (to || {hi, lo} !== exp_p) begin
      failures++;
      $display("FAIL signed_neg got %h%h exp %h timeout=%b", hi, lo, exp_p, to);
    end
    exp_p = 32'h4000_0000;
    run_mul(16'h8000, 16'h8000, bn, dn, da, to);
    checks++;
    if (to || {hi, lo} !== exp_p) begin
      failures++;
      $display("FAIL signed_minmin got %h%h exp %h", hi, lo, exp_p);
    end
    run_mul(16'h8000, 16'h0001, bn, dn, da, to);
    checks++;
    if (to || {hi, lo} !== 32'hFFFF_8000) begin
      failures++;
      $display("FAIL signed_min_x1 got %h%h exp ffff8000", hi, lo);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    @(negedge clk);
    operand_a = 16'h1234; operand_b = 16'h5678; mul_start = 1'b1;
    @(posedge clk);
    #1 mul_start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hi, lo, busy, done, stall} !== {32'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset_mid_run got hi=%h lo=%h busy=%b done=%b stall=%b", hi, lo, busy, done, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0 || {hi, lo} !== 32'h0) begin
      failures++;
      $display("FAIL reset_no_resume got active_cycles=%0d hilo=%h%h exp 0", pulses, hi, lo);
    end
    mf_req = 1'b1; mf_hi = 1'b1;
    #1;
    checks++;
    if (mf_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mfhi got %h exp 0000", mf_data);
    end
    mf_req = 1'b0;
  endtask

  task automatic test_unsigned();
    int bn, dn, da; bit to;
    run_mul(16'd3, 16'd5, bn, dn, da, to);
    checks++;
    if (to || bn !== W + 1) begin
      failures++;
      $display("FAIL unsigned_busy_len got %0d exp %0d timeout=%b", bn, W + 1, to);
    end
    checks++;
    if (dn !== 1 || da !== W + 1) begin
      failures++;
      $display("FAIL unsigned_done got count=%0d at=%0d exp 1 at %0d", dn, da, W + 1);
    end
    checks++;
    if (hi !== 16'h0000 || lo !== 16'h000F) begin
      failures++;
      $display("FAIL unsigned_result got %h/%h exp 0000/000f", hi, lo);
    end
  endtask

  task automatic test_flush();
    int pulses;
    @(negedge clk);
    operand_a = 16'h1234; operand_b = 16'h0002; mul_start = 1'b1;
    @(posedge clk);
    #1 mul_start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0 || hi !== 16'h0000 || lo !== 16'h000F) begin
      failures++;
      $display("FAIL flush_run got active=%0d hilo=%h/%h exp 0 0000/000f", pulses, hi, lo);
    end
    // Flush landing exactly on the DONE cycle.
    @(negedge clk);
    operand_a = 16'h1234; operand_b = 16'h0002; mul_start = 1'b1;
    @(posedge clk);
    #1 mul_start = 1'b0;
    repeat (W + 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL done_cycle_pos got busy=%b done=%b exp 1 1", busy, done);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL flush_done_pulse got %b exp 0", done);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 16'h0000 || lo !== 16'h000F) begin
      failures++;
      $display("FAIL flush_done got busy=%b hilo=%h/%h exp 0 0000/000f", busy, hi, lo);
    end
  endtask

  task automatic test_simul_read();
    int lat;
    logic [2*W-1:0] exp_p;
    exp_p = ref_prod(16'h0007, 16'hFFFD);
    @(negedge clk);
    operand_a = 16'h0007; operand_b = 16'hFFFD;
    mul_start = 1'b1; mf_req = 1'b1; mf_hi = 1'b0;
    #1;
    checks++;
    if (mf_data !== 16'h000F || stall !== 1'b0) begin
      failures++;
      $display("FAIL simul_read got data=%h stall=%b exp 000f 0", mf_data, stall);
    end
    @(posedge clk);
    #1 mul_start = 1'b0; mf_req = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if ({hi, lo} === exp_p) begin lat = i; break; end
    end
    checks++;
    if (lat !== W + 1) begin
      failures++;
      $display("FAIL simul_latency got %0d exp %0d", lat, W + 1);
    end
  endtask

  task automatic test_interlock();
    int st;
    bit to;
    @(negedge clk);
    operand_a = 16'h0100; operand_b = 16'h0100; mul_start = 1'b1;
    @(posedge clk);
    #1 mul_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mf_req = 1'b1; mf_hi = 1'b1;
    st = 0; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) begin to = 1'b0; break; end
      st++;
      @(negedge clk);
    end
    checks++;
    if (to || st !== W) begin
      failures++;
      $display("FAIL interlock_stall got %0d cycles exp %0d timeout=%b", st, W, to);
    end
    checks++;
    if (mf_data !== 16'h0001 || lo !== 16'h0000) begin
      failures++;
      $display("FAIL interlock_read got mf=%h lo=%h exp 0001 0000", mf_data, lo);
    end
    mf_req = 1'b0;
  endtask

  task automatic test_random();
    int bn, dn, da; bit to;
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp_p;
    logic [W-1:0] corner [5];
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int n = 0; n < 24; n++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      exp_p = ref_prod(a, b);
      run_mul(a, b, bn, dn, da, to);
      checks++;
      if (to || {hi, lo} !== exp_p || bn !== W + 1 || dn !== 1) begin
        failures++;
        $display("FAIL random a=%h b=%h got %h%h busy=%0d done=%0d exp %h busy=%0d done=1",
                 a, b, hi, lo, bn, dn, exp_p, W + 1);
      end
      mf_hi = 1'(n);
      #1;
      checks++;
      if (mf_data !== (mf_hi ? exp_p[2*W-1:W] : exp_p[W-1:0])) begin
        failures++;
        $display("FAIL random_mf sel=%b got %h exp product %h", mf_hi, mf_data, exp_p);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset_state();
    test_signed();
    test_reset_mid_run();
    test_unsigned();
    test_flush();
    test_simul_read();
    // Restore LO=0x000F-independent state is not needed beyond here.
    test_interlock();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
